// File: rtl/pp_accumulator.sv
// Partial-product accumulator: sums 3-coefficient beats mod 2^W into a register array, then drains it
// over a valid/ready port. Define NEGACYCLIC_EN for Z[x]/(x^N+1) folding (ACC_LEN=N instead of 2N).
module pp_accumulator #(
  parameter int N     = 100,
  parameter int W     = 16,
  parameter int IDX_W = 10
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             B_valid_in,
  input  logic [IDX_W-1:0] idx_B_in,
  input  logic [3*W-1:0]   B_in,
  input  logic             last_in,
  output logic             busy_out,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [IDX_W-1:0] res_idx_out,
  output logic [W-1:0]     res_data_out,
  output logic             res_last_out,
  output logic             err_out
);

`ifdef NEGACYCLIC_EN
  localparam int ACC_LEN = N;
`else
  localparam int ACC_LEN = 2 * N;
`endif
  localparam int AW = $clog2(ACC_LEN);
  localparam int PW = IDX_W + 2;
  localparam logic [PW-1:0] ACC_LEN_P = PW'(ACC_LEN);
  localparam logic [AW-1:0] LAST_CNT  = AW'(ACC_LEN - 1);
`ifdef NEGACYCLIC_EN
  localparam logic [PW-1:0] N_P  = PW'(N);
  localparam logic [PW-1:0] N2_P = PW'(2 * N);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [W-1:0]  acc_q [ACC_LEN];
  logic [W-1:0]  acc_d [ACC_LEN];

  // Target index of each coefficient, widened so idx+2 cannot overflow.
  logic [PW-1:0] pos [3];
`ifdef NEGACYCLIC_EN
  logic [PW-1:0] wrap [3];
`endif

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pos[k] = {2'b00, idx_B_in} + PW'(k);
`ifdef NEGACYCLIC_EN
      wrap[k] = pos[k] - N_P;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_ACCUM;
          err_d   = 1'b0;
          acc_d   = '{default: '0};
        end
        if (B_valid_in) err_d = 1'b1;
      end
      S_ACCUM: begin
        if (B_valid_in) begin
          // NOTE: blocking updates of acc_d chain through the loop, so every coefficient of the
          // beat lands in one read-modify-write of the registered array.
          for (int k = 0; k < 3; k++) begin
            if (pos[k] < ACC_LEN_P)
              acc_d[pos[k][AW-1:0]] = acc_d[pos[k][AW-1:0]] + B_in[k*W +: W];
`ifdef NEGACYCLIC_EN
            else if (pos[k] < N2_P)
              acc_d[wrap[k][AW-1:0]] = acc_d[wrap[k][AW-1:0]] - B_in[k*W +: W];
`endif
            else
              err_d = 1'b1;
          end
          if (last_in) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (B_valid_in) err_d = 1'b1;
        if (res_ready_in) begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: the array is flops, not RAM, so it is cleared by reset like any other state.
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_out      = (state_q != S_IDLE);
  assign res_valid_out = (state_q == S_DRAIN);
  assign res_idx_out   = res_valid_out ? IDX_W'(cnt_q) : '0;
  assign res_data_out  = res_valid_out ? acc_q[cnt_q] : '0;
  assign res_last_out  = res_valid_out && (cnt_q == LAST_CNT);
  assign err_out       = err_q;

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: a reference model fills a scoreboard queue with the expected
// drain sequence, which is compared item by item as the DUT hands out coefficients.
module tb_pp_accumulator;
  localparam int N     = 100;
  localparam int W     = 16;
  localparam int IDX_W = 10;
`ifdef NEGACYCLIC_EN
  localparam int ACC_LEN = N;
`else
  localparam int ACC_LEN = 2 * N;
`endif

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     data;
    logic             last;
  } item_t;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             start_in;
  logic             B_valid_in;
  logic [IDX_W-1:0] idx_B_in;
  logic [3*W-1:0]   B_in;
  logic             last_in;
  logic             busy_out;
  logic             res_valid_out;
  logic             res_ready_in;
  logic [IDX_W-1:0] res_idx_out;
  logic [W-1:0]     res_data_out;
  logic             res_last_out;
  logic             err_out;

  int          n_chk = 0;
  int          n_err = 0;
  item_t       sb [$];
  logic [15:0] exp_acc [ACC_LEN];
  bit          model_err;

  pp_accumulator #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .B_valid_in(B_valid_in), .idx_B_in(idx_B_in), .B_in(B_in), .last_in(last_in),
    .busy_out(busy_out), .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_idx_out(res_idx_out), .res_data_out(res_data_out), .res_last_out(res_last_out),
    .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ACC_LEN; i++) exp_acc[i] = '0;
    model_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    model_clear();
  endtask

  task automatic beat(input int idx, input logic [15:0] c0, input logic [15:0] c1,
                      input logic [15:0] c2, input bit last);
    logic [15:0] c [3];
    c[0] = c0; c[1] = c1; c[2] = c2;
    B_valid_in = 1'b1;
    idx_B_in   = IDX_W'(idx);
    B_in       = {c2, c1, c0};
    last_in    = last;
    for (int k = 0; k < 3; k++) begin
`ifdef NEGACYCLIC_EN
      if (idx + k < N)          exp_acc[idx+k]   = exp_acc[idx+k] + c[k];
      else if (idx + k < 2 * N) exp_acc[idx+k-N] = exp_acc[idx+k-N] - c[k];
      else                      model_err = 1'b1;
`else
      if (idx + k < ACC_LEN) exp_acc[idx+k] = exp_acc[idx+k] + c[k];
      else                   model_err = 1'b1;
`endif
    end
    tick();
    B_valid_in = 1'b0;
    last_in    = 1'b0;
  endtask

  task automatic push_drain();
    for (int i = 0; i < ACC_LEN; i++)
      sb.push_back('{idx: IDX_W'(i), data: exp_acc[i], last: (i == ACC_LEN - 1)});
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1. start_at: cycle to pulse start_in.
  task automatic drain(input int mode, input int target, input int start_at);
    int hs  = 0;
    int cyc = 0;
    while (hs < target && cyc < 3000) begin
      res_ready_in = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      start_in     = (cyc == start_at);
      if (res_valid_out && sb.size() > 0) begin
        check("drain_item", {res_idx_out, res_data_out, res_last_out}, sb[0]);
        if (res_ready_in) begin
          void'(sb.pop_front());
          hs++;
        end
      end
      tick();
      cyc++;
    end
    start_in     = 1'b0;
    res_ready_in = 1'b0;
    check("drain_count", hs, target);
  endtask

  task automatic check_drain_done();
    check("drain_done_valid", res_valid_out, 1'b0);
    check("drain_done_busy", busy_out, 1'b0);
  endtask

  initial begin
    rst_n_in = 1'b0; start_in = 1'b0; B_valid_in = 1'b0; idx_B_in = '0;
    B_in = '0; last_in = 1'b0; res_ready_in = 1'b0;
    model_clear();
    #1;
    check("reset_outputs", {busy_out, res_valid_out, res_idx_out, res_data_out, res_last_out, err_out}, '0);
    #20 rst_n_in = 1'b1;
    tick();

    // Basic product, continuous ready.
    do_start();
    check("t1_busy", busy_out, 1'b1);
    beat(0, 16'd1, 16'd2, 16'd3, 1'b0);
    beat(1, 16'd5, 16'd0, 16'd0, 1'b1);
    check("t1_valid_first", res_valid_out, 1'b1);
    check("t1_err", err_out, model_err);
    push_drain();
    drain(0, ACC_LEN, -1);
    check_drain_done();

    // Random overlapping beats, then wrap at acc[0]; throttled drain with ignored start.
    do_start();
    for (int i = 0; i < 30; i++)
      beat($urandom_range(3, 197), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    beat(0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
    beat(0, 16'h0001, 16'd0, 16'd0, 1'b1);
    check("t2_err", err_out, model_err);
    push_drain();
    drain(1, ACC_LEN, 5);
    check_drain_done();

    // Out-of-range coefficient, sticky error, cleared by start.
    do_start();
    beat(198, 16'd5, 16'd6, 16'd7, 1'b1);
    check("t4_err_set", err_out, model_err);
    push_drain();
    drain(0, ACC_LEN, -1);
    check_drain_done();
    check("t4_err_sticky", err_out, model_err);
    do_start();
    check("t4_err_clear", err_out, 1'b0);
    beat(0, 16'd0, 16'd0, 16'd0, 1'b1);
    push_drain();
    drain(0, ACC_LEN, -1);
    B_valid_in = 1'b1;
    tick();
    B_valid_in = 1'b0;
    check("idle_beat_err", err_out, 1'b1);

`ifdef NEGACYCLIC_EN
    do_start();
    beat(99, 16'd1, 16'd2, 16'd3, 1'b1);
    check("t5_err", err_out, model_err);
    push_drain();
    drain(0, ACC_LEN, -1);
    check_drain_done();
`endif

    // Asynchronous reset in the middle of a drain.
    do_start();
    beat(10, 16'h1234, 16'h5678, 16'h9ABC, 1'b0);
    beat(199, 16'h0011, 16'h0022, 16'h0033, 1'b0);
    beat(40, 16'hBEEF, 16'h0001, 16'h0002, 1'b1);
    push_drain();
    drain(0, 40, -1);
    check("t6_cnt40", res_idx_out, IDX_W'(40));
    check("t6_err_before", err_out, model_err);
    #2 rst_n_in = 1'b0;
    #1;
    check("t6_async_clear", {busy_out, res_valid_out, res_idx_out, res_data_out, res_last_out, err_out}, '0);
    #13 rst_n_in = 1'b1;
    sb.delete();
    model_clear();
    tick();
    check("t6_idle", {busy_out, res_valid_out}, 2'b00);
    do_start();
    beat(0, 16'd0, 16'd0, 16'd0, 1'b1);
    push_drain();
    drain(0, ACC_LEN, -1);
    check_drain_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
